// File: rtl/stopwatch_lap_timer_if.sv
// Control/status bundle between the button/display front end and the stopwatch core.
// The master drives the control pulses and the preset; the slave returns time, flags and lap FIFO state.
interface stopwatch_lap_timer_if #(
  parameter int unsigned LAP_DEPTH = 4
);
  localparam int unsigned TIME_W = 24;
  localparam int unsigned CNT_W  = $clog2(LAP_DEPTH + 1);

  logic              start_stop;
  logic              clear;
  logic              preset_load;
  logic [TIME_W-1:0] preset;
  logic              down_mode;
  logic              lap;
  logic              lap_pop;
  logic [TIME_W-1:0] time_bcd;
  logic              running;
  logic              expired;
  logic              wrap;
  logic [TIME_W-1:0] lap_bcd;
  logic              lap_valid;
  logic [CNT_W-1:0]  lap_count;
  logic              lap_overflow;

  modport master (
    output start_stop, clear, preset_load, preset, down_mode, lap, lap_pop,
    input  time_bcd, running, expired, wrap, lap_bcd, lap_valid, lap_count, lap_overflow
  );

  modport slave (
    input  start_stop, clear, preset_load, preset, down_mode, lap, lap_pop,
    output time_bcd, running, expired, wrap, lap_bcd, lap_valid, lap_count, lap_overflow
  );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch core: mm:ss:cc BCD up/down counter with 10 ms prescaler, run/stop FSM
// and a show-ahead lap-capture FIFO. All status outputs come straight from registers.
module stopwatch_lap_timer #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  stopwatch_lap_timer_if.slave  bus
);
  localparam int unsigned TIME_W = 24;
  localparam int unsigned NDIG   = 6;
  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned CNT_W  = $clog2(LAP_DEPTH + 1);
  localparam int unsigned PTR_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t            state, state_n;
  logic [PRE_W-1:0]  presc, presc_n;
  logic [TIME_W-1:0] time_q, time_n;
  logic              expired_q, expired_n;
  logic              wrap_q, wrap_n;
  logic              ovf_q, ovf_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PTR_W-1:0]  rd, rd_n, wr, wr_n;
  logic [TIME_W-1:0] head_q, head_n;
  logic              do_push, do_pop, tick;
  logic [TIME_W-1:0] mem [LAP_DEPTH];

  // Seconds-tens and minutes-tens digits roll at 5, all others at 9.
  function automatic logic [3:0] dig_lim(input int unsigned i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  // Returns {carry_out, incremented time}; carry_out marks the 59:59:99 rollover.
  function automatic logic [TIME_W:0] bcd_inc(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] r;
    logic              c;
    r = t;
    c = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= dig_lim(i)) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] r;
    logic              b;
    r = t;
    b = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = dig_lim(i);
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TIME_W-1:0] bcd_clamp(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] r;
    for (int unsigned i = 0; i < NDIG; i++)
      r[4*i +: 4] = (t[4*i +: 4] > dig_lim(i)) ? dig_lim(i) : t[4*i +: 4];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LAP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign tick = (state == ST_RUN) && (presc == PRE_W'(TICK_DIV - 1));

  // Next-state: clear > preset_load > {start_stop, tick, lap FIFO}.
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    time_n    = time_q;
    expired_n = expired_q;
    wrap_n    = 1'b0;
    ovf_n     = ovf_q;
    cnt_n     = cnt;
    rd_n      = rd;
    wr_n      = wr;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    head_n    = '0;

    if (bus.clear) begin
      state_n   = ST_STOP;
      presc_n   = '0;
      time_n    = '0;
      expired_n = 1'b0;
      ovf_n     = 1'b0;
      cnt_n     = '0;
      rd_n      = '0;
      wr_n      = '0;
    end else if (bus.preset_load) begin
      state_n   = ST_STOP;
      presc_n   = '0;
      time_n    = bcd_clamp(bus.preset);
      expired_n = 1'b0;
    end else begin
      if (state == ST_RUN) presc_n = tick ? '0 : presc + PRE_W'(1);

      if (bus.start_stop) begin
        if (state == ST_RUN) state_n = ST_STOP;
        else if (!(bus.down_mode && time_q == '0)) begin
          state_n   = ST_RUN;
          expired_n = 1'b0;
        end
      end

      if (tick) begin
        if (bus.down_mode) begin
          time_n = bcd_dec(time_q);
          if (time_n == '0) begin
            state_n   = ST_STOP;
            expired_n = 1'b1;
          end
        end else begin
          {wrap_n, time_n} = bcd_inc(time_q);
        end
      end

      // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
      do_pop  = bus.lap_pop && (cnt != '0);
      do_push = bus.lap && ((cnt != CNT_W'(LAP_DEPTH)) || do_pop);
      if (bus.lap && !do_push) ovf_n = 1'b1;
      if (do_pop)  rd_n = ptr_inc(rd);
      if (do_push) wr_n = ptr_inc(wr);
      cnt_n = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    if (cnt_n != '0) head_n = (do_push && rd_n == wr) ? time_q : mem[rd_n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOP;
      presc     <= '0;
      time_q    <= '0;
      expired_q <= 1'b0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt       <= '0;
      rd        <= '0;
      wr        <= '0;
      head_q    <= '0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      time_q    <= time_n;
      expired_q <= expired_n;
      wrap_q    <= wrap_n;
      ovf_q     <= ovf_n;
      cnt       <= cnt_n;
      rd        <= rd_n;
      wr        <= wr_n;
      head_q    <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr] <= time_q;
  end

  assign bus.time_bcd     = time_q;
  assign bus.running      = (state == ST_RUN);
  assign bus.expired      = expired_q;
  assign bus.wrap         = wrap_q;
  assign bus.lap_bcd      = head_q;
  assign bus.lap_valid    = (cnt != '0);
  assign bus.lap_count    = cnt;
  assign bus.lap_overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench for stopwatch_lap_timer with TICK_DIV=4, LAP_DEPTH=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_lap_timer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  stopwatch_lap_timer_if #(.LAP_DEPTH(4)) bus ();

  stopwatch_lap_timer #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_time"},  32'(bus.time_bcd), 32'h0);
    chk({tag, "_run"},   32'(bus.running), 32'h0);
    chk({tag, "_exp"},   32'(bus.expired), 32'h0);
    chk({tag, "_wrap"},  32'(bus.wrap), 32'h0);
    chk({tag, "_lbcd"},  32'(bus.lap_bcd), 32'h0);
    chk({tag, "_lval"},  32'(bus.lap_valid), 32'h0);
    chk({tag, "_lcnt"},  32'(bus.lap_count), 32'h0);
    chk({tag, "_lovf"},  32'(bus.lap_overflow), 32'h0);
  endtask

  task automatic pulse_ss();
    bus.start_stop = 1'b1; step(1); bus.start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clear = 1'b1; step(1); bus.clear = 1'b0;
  endtask

  task automatic load(input logic [23:0] v);
    bus.preset = v; bus.preset_load = 1'b1; step(1); bus.preset_load = 1'b0;
  endtask

  task automatic pulse_lap();
    bus.lap = 1'b1; step(1); bus.lap = 1'b0;
  endtask

  task automatic pulse_pop();
    bus.lap_pop = 1'b1; step(1); bus.lap_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.preset_load = 1'b0;
    bus.preset = '0; bus.down_mode = 1'b0; bus.lap = 1'b0; bus.lap_pop = 1'b0;

    // Reset state
    step(1);
    chk_zero("rst");
    step(1);
    reset = 1'b0;

    // Run from reset: first tick lands four cycles after running rises
    pulse_ss();
    chk("run_on", 32'(bus.running), 32'h1);
    step(3);
    chk("pre_tick", 32'(bus.time_bcd), 32'h000000);
    step(1);
    chk("tick1", 32'(bus.time_bcd), 32'h000001);
    step(99 * 4);
    chk("tick100", 32'(bus.time_bcd), 32'h000100);

    // Pause/resume keeps the partial prescaler count
    pulse_clr();
    chk("clr_time", 32'(bus.time_bcd), 32'h0);
    chk("clr_run", 32'(bus.running), 32'h0);
    pulse_ss();
    step(1);
    pulse_ss();
    chk("paused", 32'(bus.running), 32'h0);
    pulse_ss();
    step(1);
    chk("resume_early", 32'(bus.time_bcd), 32'h000000);
    step(1);
    chk("resume_tick", 32'(bus.time_bcd), 32'h000001);
    pulse_ss();

    // Up-count rollover
    load(24'h595998);
    chk("ld_time", 32'(bus.time_bcd), 32'h595998);
    chk("ld_run", 32'(bus.running), 32'h0);
    pulse_ss();
    step(4);
    chk("up_99", 32'(bus.time_bcd), 32'h595999);
    chk("up_nowrap", 32'(bus.wrap), 32'h0);
    step(4);
    chk("wrap_time", 32'(bus.time_bcd), 32'h000000);
    chk("wrap_hi", 32'(bus.wrap), 32'h1);
    chk("wrap_run", 32'(bus.running), 32'h1);
    step(1);
    chk("wrap_lo", 32'(bus.wrap), 32'h0);
    pulse_ss();

    // Preset clamping
    load(24'h009000);
    chk("clamp_s10", 32'(bus.time_bcd), 32'h005000);
    load(24'hFFFFFF);
    chk("clamp_all", 32'(bus.time_bcd), 32'h595999);

    // Countdown to expiry
    bus.down_mode = 1'b1;
    load(24'h000003);
    pulse_ss();
    step(4);
    chk("dn_2", 32'(bus.time_bcd), 32'h000002);
    step(4);
    chk("dn_1", 32'(bus.time_bcd), 32'h000001);
    chk("dn_noexp", 32'(bus.expired), 32'h0);
    step(4);
    chk("dn_0", 32'(bus.time_bcd), 32'h000000);
    chk("dn_exp", 32'(bus.expired), 32'h1);
    chk("dn_stop", 32'(bus.running), 32'h0);
    pulse_ss();
    chk("dn_ignore", 32'(bus.running), 32'h0);
    chk("dn_exp_hold", 32'(bus.expired), 32'h1);
    bus.down_mode = 1'b0;

    // Lap FIFO: fill, overflow, drain
    pulse_clr();
    load(24'h000011); pulse_lap();
    chk("lap1_cnt", 32'(bus.lap_count), 32'h1);
    chk("lap1_val", 32'(bus.lap_valid), 32'h1);
    chk("lap1_bcd", 32'(bus.lap_bcd), 32'h000011);
    load(24'h000022); pulse_lap();
    load(24'h000033); pulse_lap();
    load(24'h000044); pulse_lap();
    chk("lap4_ovf", 32'(bus.lap_overflow), 32'h0);
    load(24'h000055); pulse_lap();
    chk("lap5_cnt", 32'(bus.lap_count), 32'h4);
    chk("lap5_ovf", 32'(bus.lap_overflow), 32'h1);
    chk("lap5_bcd", 32'(bus.lap_bcd), 32'h000011);
    pulse_pop();
    chk("pop1", 32'(bus.lap_bcd), 32'h000022);
    pulse_pop();
    chk("pop2", 32'(bus.lap_bcd), 32'h000033);
    pulse_pop();
    chk("pop3", 32'(bus.lap_bcd), 32'h000044);
    pulse_pop();
    chk("pop4_bcd", 32'(bus.lap_bcd), 32'h000000);
    chk("pop4_val", 32'(bus.lap_valid), 32'h0);
    pulse_pop();
    chk("pop_empty", 32'(bus.lap_count), 32'h0);

    // Push and pop together while full
    load(24'h000011); pulse_lap();
    load(24'h000022); pulse_lap();
    load(24'h000033); pulse_lap();
    load(24'h000044); pulse_lap();
    load(24'h000066);
    bus.lap = 1'b1; bus.lap_pop = 1'b1; step(1); bus.lap = 1'b0; bus.lap_pop = 1'b0;
    chk("pp_cnt", 32'(bus.lap_count), 32'h4);
    chk("pp_bcd", 32'(bus.lap_bcd), 32'h000022);
    pulse_pop(); pulse_pop(); pulse_pop();
    chk("pp_last", 32'(bus.lap_bcd), 32'h000066);

    // clear beats start_stop in the same cycle
    bus.clear = 1'b1; bus.start_stop = 1'b1; step(1); bus.clear = 1'b0; bus.start_stop = 1'b0;
    chk("pri_time", 32'(bus.time_bcd), 32'h0);
    chk("pri_run", 32'(bus.running), 32'h0);
    chk("pri_cnt", 32'(bus.lap_count), 32'h0);
    chk("pri_ovf", 32'(bus.lap_overflow), 32'h0);

    // Reset mid-run
    pulse_ss();
    step(9);
    chk("mid_time", 32'(bus.time_bcd), 32'h000002);
    pulse_lap();
    chk("mid_cnt", 32'(bus.lap_count), 32'h1);
    reset = 1'b1;
    step(1);
    chk_zero("mid_rst");
    reset = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap_timer.md
# stopwatch_lap_timer

Parametrised stopwatch core with start/stop, clear, preset load, up or down (countdown) mode and a lap-capture FIFO. It produces a 6-digit packed BCD time (mm:ss:cc) plus status flags. The 7-segment display path (`sseg_driver`) and the button debouncers are external to this block. All control inputs are single-cycle pulses from the debouncer/edge-detect stage.

## Interface
- `TICK_DIV`, 1000000, clk cycles per 10 ms tick (≥2)
- `LAP_DEPTH`, 4, lap FIFO entries (≥1)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start_stop`  in  1  pulse; toggles run state
- `clear`  in  1  pulse; zero time, stop, empty FIFO, clear flags
- `preset_load`  in  1  pulse; load `preset`, stop, clear `expired`
- `preset`  in  24  BCD {m10,m1,s10,s1,c10,c1}, 4 bits each, MSB first
- `down_mode`  in  1  0 = count up, 1 = count down
- `lap`  in  1  pulse; push current `time_bcd` into FIFO
- `lap_pop`  in  1  pulse; discard oldest FIFO entry
- `time_bcd`  out  24  current time, same packing as `preset`
- `running`  out  1  counter enabled
- `expired`  out  1  sticky; countdown reached 00:00:00
- `wrap`  out  1  one-cycle pulse on up-count rollover 59:59:99→00:00:00
- `lap_bcd`  out  24  oldest FIFO entry (show-ahead); 0 when empty
- `lap_valid`  out  1  FIFO non-empty
- `lap_count`  out  $clog2(LAP_DEPTH+1)  entries held
- `lap_overflow`  out  1  sticky; a push was dropped while full

## Operation
- Reset: all outputs 0; prescaler 0; FIFO empty.
- Priority per cycle: `reset` > `clear` > `preset_load` > {`start_stop`, `lap`, `lap_pop`, tick}.
- Prescaler: counts 0..TICK_DIV-1 only while `running`. Tick occurs in the cycle it equals TICK_DIV-1, and the prescaler returns to 0. It holds its value while stopped, so resume keeps the fractional tick. Zeroed by reset, `clear`, `preset_load`.
- Digit limits: c1 9, c10 9, s1 9, s10 5, m1 9, m10 5. Each carry/borrow ripples in the same cycle.
- Up mode: on tick, increment. 59:59:99 + 1 → 00:00:00, `wrap`=1 for one cycle, keep running.
- Down mode: on tick, decrement. When the result is 00:00:00, `running`←0 and `expired`←1 in the same update.
- `start_stop` while stopped in down mode with time 00:00:00 is ignored.
- `down_mode` is sampled at each tick. Changing it mid-run affects the next tick only.
- Preset digits above their limit load as the limit; e.g. s10=7 loads 5.
- `expired` is cleared by reset, `clear`, `preset_load`, or a `start_stop` that actually starts counting.
- Lap FIFO:
  - Push value is the registered `time_bcd` of the pushing cycle, i.e. the pre-tick value if a tick coincides.
  - Push when full with no pop: entry dropped, `lap_overflow`←1.
  - Push and pop together when full: both take effect, and the count is unchanged.
  - Pop when empty: ignored.
  - `lap` is accepted whether running or stopped.

## Timing
- All outputs are registered.
- `start_stop` at cycle N → `running` changes at N+1.
- Starting from prescaler 0 at cycle N+1: the first tick is at cycle N+TICK_DIV, and `time_bcd` updates at N+TICK_DIV+1.
- Tick result, `wrap`, `expired` and the `running` drop all appear together one cycle after the tick.
- `lap` at N → `lap_count`/`lap_valid` update at N+1. `lap_bcd` shows the entry at N+1 if the FIFO was empty.
- `lap_pop` at N → next entry (or 0) on `lap_bcd` at N+1.
- `clear`/`preset_load` at N → new time and stopped at N+1.
- A tick in the same cycle as a `start_stop` stop is still applied.

## Test plan
- Run from reset: TICK_DIV=4, reset, `start_stop` at cycle 0 → `time_bcd`=00:00:01 at cycle 5. Check 00:01:00 after 100 ticks; all outputs 0 during reset.
- Up wrap: preset 59:59:98, start, 2 ticks → 00:00:00, `wrap` high exactly one cycle, `running` stays 1.
- Countdown:
  - Preset 00:00:03, `down_mode`=1, start → 00:00:00 after 3 ticks, `expired`=1, `running`=0.
  - A further `start_stop` keeps `running`=0.
  - Preset with s10=9 loads 5.
- Lap FIFO (LAP_DEPTH=4):
  - 5 laps at distinct times → `lap_count`=4, `lap_overflow`=1, `lap_bcd`=first lap.
  - 4 pops return laps 1–4 in order, then `lap_valid`=0.
  - Push+pop together when full keeps the count at 4.
- Pause/resume: TICK_DIV=4, start, stop after 2 cycles, restart → tick occurs 2 cycles after restart, not 4.
- Priority/reset:
  - `clear`+`start_stop` in the same cycle → 00:00:00, stopped, FIFO empty.
  - `reset` asserted mid-run → all outputs 0 next cycle.
